// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard logic.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MDU_WAIT = 2'd2
  } hazard_state_t;

  localparam int REG_ZERO = 0;

  // Total bubble counts per hazard class.
  localparam logic [1:0] STALL_LOAD_BR = 2'd2;
  localparam logic [1:0] STALL_LOAD    = 2'd1;
  localparam logic [1:0] STALL_ALU_BR  = 2'd1;

endpackage

// File: rtl/hazard_dep_cmp.sv
// Source/destination register dependence compare; r0 never creates a dependence.
module hazard_dep_cmp
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rt,
  input  logic [REG_ADDR_W-1:0] dst,
  output logic                  dep
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (dst == rs);
  assign rt_hit = uses_rt && (dst == rt);
  assign dep    = (rs_hit || rt_hit) && (dst != REG_ADDR_W'(REG_ZERO));

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use, branch-operand and MDU result stalls.
// Define HAZARD_PERF_CNT_EN to build the stallCycles performance counter.
module hazard_stall_unit
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifIdRs,
  input  logic [REG_ADDR_W-1:0] ifIdRt,
  input  logic                  ifIdUsesRt,
  input  logic                  branchInId,
  input  logic                  branchTaken,
  input  logic                  ifIdUsesMdu,
  input  logic                  idExMemRead,
  input  logic                  idExRegWrite,
  input  logic [REG_ADDR_W-1:0] idExRd,
  input  logic                  mduStart,
  input  logic                  mduDone,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  idExFlush,
  output logic                  ifIdFlush,
  output logic [31:0]           stallCycles
);

  hazard_state_t state, state_n;
  logic [1:0]    stall_left, stall_left_n;
  logic [1:0]    need;
  logic          dep;
  logic          stall;

  hazard_dep_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_dep (
    .rs      (ifIdRs),
    .rt      (ifIdRt),
    .uses_rt (ifIdUsesRt),
    .dst     (idExRd),
    .dep     (dep)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    need = 2'd0;
    if (idExMemRead && dep)
      need = branchInId ? STALL_LOAD_BR : STALL_LOAD;
    else if (branchInId && idExRegWrite && dep)
      need = STALL_ALU_BR;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      stall_left <= 2'd0;
    end else begin
      state      <= state_n;
      stall_left <= stall_left_n;
    end
  end

  always_comb begin
    state_n      = state;
    stall_left_n = stall_left;
    case (state)
      RUN: begin
        if (need != 2'd0) begin
          stall_left_n = need - 2'd1;
          state_n      = (need > 2'd1) ? STALL : RUN;
        end else if (mduStart) begin
          state_n = MDU_WAIT;
        end
      end
      STALL: begin
        stall_left_n = (stall_left == 2'd0) ? 2'd0 : stall_left - 2'd1;
        // The cycle that drains stallLeft to zero is the last bubble.
        if (stall_left <= 2'd1)
          state_n = RUN;
      end
      MDU_WAIT: begin
        if (mduDone)
          state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      RUN:      stall = (need != 2'd0);
      STALL:    stall = 1'b1;
      MDU_WAIT: stall = ifIdUsesMdu && !mduDone;
      default:  stall = 1'b0;
    endcase
    // Outputs must read non-stall while reset is held, whatever the inputs show.
    if (rst)
      stall = 1'b0;
    pcWrite   = !stall;
    ifIdWrite = !stall;
    idExFlush = stall;
    ifIdFlush = !rst && !stall && branchInId && branchTaken;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 32'd0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign stallCycles = stall_cnt;
`else
  assign stallCycles = 32'd0;
`endif

  // EX holds a bubble during STALL, so an MDU issue there is a pipeline bug.
  mdu_start_in_stall : assert property (@(posedge clk) disable iff (rst)
    !(state == STALL && mduStart))
    else $error("mduStart pulsed while in STALL");

endmodule
